// File: rtl/router_pkg.sv
// Shared constants and helpers for the router datapath: byte width, the
// invalid destination code and the header field layout.
package router_pkg;

  localparam int         ROUTER_WIDTH = 8;
  localparam logic [1:0] ADDR_INVALID = 2'b11;

  localparam int HDR_DEST_LSB = 0;
  localparam int HDR_DEST_MSB = 1;
  localparam int HDR_LEN_LSB  = 2;
  localparam int HDR_LEN_MSB  = 7;

  function automatic logic addr_valid(input logic [HDR_DEST_MSB:HDR_DEST_LSB] dest);
    return (dest != ADDR_INVALID);
  endfunction

  function automatic logic [HDR_LEN_MSB-HDR_LEN_LSB:0] hdr_len(input logic [ROUTER_WIDTH-1:0] hdr);
    return hdr[HDR_LEN_MSB:HDR_LEN_LSB];
  endfunction

endpackage

// File: rtl/router_reg_if.sv
// Bundle between the router control FSM / source side (master) and the
// datapath register stage (slave).
interface router_reg_if
  import router_pkg::*;
#(
  parameter int WIDTH = ROUTER_WIDTH
) ();

  logic             pkt_valid;
  logic [WIDTH-1:0] data_in;
  logic             fifo_full;
  logic             detect_add;
  logic             lfd_state;
  logic             ld_state;
  logic             full_state;
  logic             laf_state;
  logic             rst_int_reg;
  logic [WIDTH-1:0] dout;
  logic             parity_done;
  logic             low_pkt_valid;
  logic             err;

  modport master (
    output pkt_valid, data_in, fifo_full, detect_add, lfd_state,
           ld_state, full_state, laf_state, rst_int_reg,
    input  dout, parity_done, low_pkt_valid, err
  );

  modport slave (
    input  pkt_valid, data_in, fifo_full, detect_add, lfd_state,
           ld_state, full_state, laf_state, rst_int_reg,
    output dout, parity_done, low_pkt_valid, err
  );

endinterface

// File: rtl/router_parity_acc.sv
// Running XOR accumulator for packet bytes plus the captured parity byte;
// mismatch_o compares the two.
module router_parity_acc
  import router_pkg::*;
#(
  parameter int WIDTH = ROUTER_WIDTH
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             cap_i,
  input  logic [WIDTH-1:0] cap_din_i,
  output logic             mismatch_o
);

  function automatic logic [WIDTH-1:0] par_fold(input logic [WIDTH-1:0] acc,
                                                input logic [WIDTH-1:0] b);
    return acc ^ b;
  endfunction

  logic [WIDTH-1:0] int_par_q, int_par_d;
  logic [WIDTH-1:0] pkt_par_q, pkt_par_d;

  // Next-state for the accumulator (clear beats enable) and the parity capture.
  always_comb begin
    int_par_d = int_par_q;
    pkt_par_d = pkt_par_q;
    if (clr_i) begin
      int_par_d = {WIDTH{1'b0}};
    end else if (en_i) begin
      int_par_d = par_fold(int_par_q, din_i);
    end else begin
      int_par_d = int_par_q;
    end
    if (cap_i) begin
      pkt_par_d = cap_din_i;
    end else begin
      pkt_par_d = pkt_par_q;
    end
  end

  // Parity state registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      int_par_q <= {WIDTH{1'b0}};
      pkt_par_q <= {WIDTH{1'b0}};
    end else begin
      int_par_q <= int_par_d;
      pkt_par_q <= pkt_par_d;
    end
  end

  assign mismatch_o = (int_par_q != pkt_par_q);

endmodule

// File: rtl/router_reg.sv
// Router datapath register stage: latches the header, steers payload to the
// FIFO write port (parking one byte while full) and tracks packet parity.
module router_reg
  import router_pkg::*;
#(
  parameter int WIDTH = ROUTER_WIDTH
) (
  input  logic         clock,
  input  logic         resetn,
  router_reg_if.slave  bus
);

  logic [WIDTH-1:0] hdr_q, hdr_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             parity_done_q, parity_done_d;
  logic             low_pkt_valid_q, low_pkt_valid_d;
  logic             err_q, err_d;

  logic             par_en_s;
  logic             par_cap_s;
  logic             par_mismatch_s;
  logic [WIDTH-1:0] par_din_s;

  // The header is folded in during Load_First_Data; held bytes were already
  // counted when they arrived, so Load_After_Full adds nothing.
  assign par_en_s  = bus.lfd_state || (bus.ld_state && bus.pkt_valid && !bus.full_state);
  assign par_din_s = bus.lfd_state ? hdr_q : bus.data_in;
  assign par_cap_s = bus.ld_state && !bus.pkt_valid && !low_pkt_valid_q;

  router_parity_acc #(
    .WIDTH (WIDTH)
  ) u_parity_acc (
    .clock      (clock),
    .resetn     (resetn),
    .clr_i      (bus.detect_add),
    .en_i       (par_en_s),
    .din_i      (par_din_s),
    .cap_i      (par_cap_s),
    .cap_din_i  (bus.data_in),
    .mismatch_o (par_mismatch_s)
  );

  // Next-state for header, steering registers and status flags.
  always_comb begin
    hdr_d           = hdr_q;
    hold_d          = hold_q;
    dout_d          = dout_q;
    parity_done_d   = parity_done_q;
    low_pkt_valid_d = low_pkt_valid_q;
    err_d           = err_q;

    if (bus.detect_add && bus.pkt_valid &&
        addr_valid(bus.data_in[HDR_DEST_MSB:HDR_DEST_LSB])) begin
      hdr_d = bus.data_in;
    end else begin
      hdr_d = hdr_q;
    end

    if (bus.lfd_state) begin
      dout_d = hdr_q;
    end else if (bus.ld_state && !bus.fifo_full) begin
      dout_d = bus.data_in;
    end else if (bus.ld_state) begin
      hold_d = bus.data_in;
    end else if (bus.laf_state) begin
      dout_d = hold_q;
    end else begin
      dout_d = dout_q;
    end

    if (bus.rst_int_reg) begin
      low_pkt_valid_d = 1'b0;
    end else if (bus.ld_state && !bus.pkt_valid) begin
      low_pkt_valid_d = 1'b1;
    end else begin
      low_pkt_valid_d = low_pkt_valid_q;
    end

    // A parity byte parked in hold completes only when Load_After_Full re-emits it.
    if (bus.detect_add) begin
      parity_done_d = 1'b0;
    end else if ((bus.ld_state && !bus.fifo_full && !bus.pkt_valid && !low_pkt_valid_q) ||
                 (bus.laf_state && low_pkt_valid_q && !parity_done_q)) begin
      parity_done_d = 1'b1;
    end else begin
      parity_done_d = parity_done_q;
    end

    if (bus.rst_int_reg && parity_done_q) begin
      err_d = par_mismatch_s;
    end else if (bus.detect_add && bus.pkt_valid) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  // Datapath registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      hdr_q           <= {WIDTH{1'b0}};
      hold_q          <= {WIDTH{1'b0}};
      dout_q          <= {WIDTH{1'b0}};
      parity_done_q   <= 1'b0;
      low_pkt_valid_q <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      hdr_q           <= hdr_d;
      hold_q          <= hold_d;
      dout_q          <= dout_d;
      parity_done_q   <= parity_done_d;
      low_pkt_valid_q <= low_pkt_valid_d;
      err_q           <= err_d;
    end
  end

  assign bus.dout          = dout_q;
  assign bus.parity_done   = parity_done_q;
  assign bus.low_pkt_valid = low_pkt_valid_q;
  assign bus.err           = err_q;

endmodule
